// File: rtl/cpu_types.sv
// Shared CPU types for the load/store unit: funct3 access-size codes, LSU FSM
// state encoding and small size/mask helpers.
package cpu_types;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_size_t;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_LO   = 2'd1;
    localparam lsu_state_t ST_HI   = 2'd2;
    localparam lsu_state_t ST_RESP = 2'd3;

    // Access width in bytes; 0 marks an illegal funct3 code.
    function automatic logic [2:0] size_bytes(input mem_size_t size);
        logic [2:0] n;
        case (size)
            MEM_B, MEM_BU: n = 3'd1;
            MEM_H, MEM_HU: n = 3'd2;
            MEM_W:         n = 3'd4;
            default:       n = 3'd0;
        endcase
        return n;
    endfunction

    // Byte lanes touched across the two-word window {hi, lo}.
    function automatic logic [7:0] byte_mask8(input logic [2:0] n, input logic [1:0] off);
        logic [7:0] base;
        case (n)
            3'd1:    base = 8'h01;
            3'd2:    base = 8'h03;
            3'd4:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: extracts the addressed bytes from the {hi, lo} word pair
// and sign- or zero-extends them according to the access size.
module lsu_load_align
    import cpu_types::*;
(
    input  logic [31:0] hi_word,
    input  logic [31:0] lo_word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [63:0] shifted_s;
    logic [31:0] word_s;

    // Shift the window down to the access offset, then extend to 32 bits.
    always_comb begin
        shifted_s = {hi_word, lo_word} >> {off, 3'b000};
        word_s    = shifted_s[31:0];
        case (mem_size_t'(funct3))
            MEM_B:   rdata = {{24{word_s[7]}}, word_s[7:0]};
            MEM_H:   rdata = {{16{word_s[15]}}, word_s[15:0]};
            MEM_BU:  rdata = {24'h000000, word_s[7:0]};
            MEM_HU:  rdata = {16'h0000, word_s[15:0]};
            default: rdata = word_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store sequencer between execute and the word-addressed data RAM.
// Splits word-crossing accesses into a LO and a HI RAM cycle.
module lsu_mem_access
    import cpu_types::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [3:0]  mem_wbe,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state_r;
    logic [1:0]  off_r;
    logic [2:0]  funct3_r;
    logic        store_r;
    logic [31:0] wdata_r;
    logic [7:0]  mask8_r;
    logic        cross_r;
    logic [31:0] lo_word_r;
    logic [31:0] hi_word_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic [31:0] mem_a_r;
    logic [31:0] mem_wd_r;
    logic        mem_we_r;
    logic [3:0]  mem_wbe_r;

    logic [2:0]  req_n_s;
    logic [1:0]  req_off_s;
    logic        req_misal_s;
    logic        req_err_s;
    logic [3:0]  req_end_s;
    logic [5:0]  hi_sh_s;
    logic [31:0] align_lo_s;
    logic [31:0] align_hi_s;
    logic [31:0] align_rdata_s;

    // Decode the incoming request so the accept edge can set up the LO cycle.
    always_comb begin
        req_n_s     = size_bytes(mem_size_t'(req_funct3));
        req_off_s   = req_addr[1:0];
        req_misal_s = |(req_off_s & (req_n_s[1:0] - 2'd1));
        req_err_s   = (req_n_s == 3'd0) || (req_misal_s && !ALLOW_MISALIGNED);
        req_end_s   = {2'b00, req_off_s} + {1'b0, req_n_s};
        hi_sh_s     = 6'd32 - {1'b0, off_r, 3'b000};
    end

    // The HI cycle takes its low bytes from lo_word; a non-crossing load uses mem_rd directly.
    always_comb begin
        if (state_r == ST_HI) begin
            align_lo_s = lo_word_r;
            align_hi_s = mem_rd;
        end else begin
            align_lo_s = mem_rd;
            align_hi_s = hi_word_r;
        end
    end

    lsu_load_align u_align (
        .hi_word (align_hi_s),
        .lo_word (align_lo_s),
        .off     (off_r),
        .funct3  (funct3_r),
        .rdata   (align_rdata_s)
    );

    // Sequencer FSM; RAM drive is registered alongside the state so it is zero outside LO/HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            off_r        <= 2'b00;
            funct3_r     <= 3'd0;
            store_r      <= 1'b0;
            wdata_r      <= 32'h0;
            mask8_r      <= 8'h00;
            cross_r      <= 1'b0;
            lo_word_r    <= 32'h0;
            hi_word_r    <= 32'h0;
            resp_rdata_r <= 32'h0;
            resp_err_r   <= 1'b0;
            mem_a_r      <= 32'h0;
            mem_wd_r     <= 32'h0;
            mem_we_r     <= 1'b0;
            mem_wbe_r    <= 4'h0;
        end else begin
            mem_a_r   <= 32'h0;
            mem_wd_r  <= 32'h0;
            mem_we_r  <= 1'b0;
            mem_wbe_r <= 4'h0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        off_r        <= req_off_s;
                        funct3_r     <= req_funct3;
                        store_r      <= req_store;
                        wdata_r      <= req_wdata;
                        mask8_r      <= byte_mask8(req_n_s, req_off_s);
                        cross_r      <= (req_end_s > 4'd4);
                        resp_rdata_r <= 32'h0;
                        if (req_err_s) begin
                            resp_err_r <= 1'b1;
                            state_r    <= ST_RESP;
                        end else begin
                            resp_err_r <= 1'b0;
                            mem_a_r    <= {req_addr[31:2], 2'b00};
                            mem_we_r   <= req_store;
                            mem_wbe_r  <= req_store ? byte_mask8(req_n_s, req_off_s) : 4'h0;
                            mem_wd_r   <= req_store ? (req_wdata << {req_off_s, 3'b000}) : 32'h0;
                            state_r    <= ST_LO;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    if (!store_r) begin
                        lo_word_r <= mem_rd;
                    end else begin
                        lo_word_r <= lo_word_r;
                    end
                    if (cross_r) begin
                        mem_a_r   <= mem_a_r + 32'd4;
                        mem_we_r  <= store_r;
                        mem_wbe_r <= store_r ? mask8_r[7:4] : 4'h0;
                        mem_wd_r  <= store_r ? (wdata_r >> hi_sh_s) : 32'h0;
                        state_r   <= ST_HI;
                    end else begin
                        resp_rdata_r <= store_r ? 32'h0 : align_rdata_s;
                        state_r      <= ST_RESP;
                    end
                end
                ST_HI: begin
                    if (!store_r) begin
                        hi_word_r <= mem_rd;
                    end else begin
                        hi_word_r <= hi_word_r;
                    end
                    resp_rdata_r <= store_r ? 32'h0 : align_rdata_s;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_rdata_r <= 32'h0;
                        resp_err_r   <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == ST_IDLE) && !rst;
    assign resp_valid = (state_r == ST_RESP);
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_a      = mem_a_r;
    assign mem_wd     = mem_wd_r;
    assign mem_we     = mem_we_r;
    assign mem_wbe    = mem_wbe_r;

endmodule
